// File: rtl/button_debouncer.sv
// Pushbutton front-end: two-flop synchroniser, debounce filter FSM, and
// registered level / press / release / long-press strobes with a press counter.
module button_debouncer #(
  parameter int CLK_FREQ_HZ   = 50_000_000,
  parameter int DEBOUNCE_MS   = 20,
  parameter int LONG_PRESS_MS = 1000,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int DB_CYC = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;
  localparam int LP_CYC = CLK_FREQ_HZ / 1000 * LONG_PRESS_MS;
  localparam int CW     = $clog2(DB_CYC + 1);
  localparam int LW     = $clog2(LP_CYC + 1);

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] DB_LAST  = CW'(DB_CYC);
  localparam logic [LW-1:0] LP_ONE   = LW'(1);
  localparam logic [LW-1:0] LP_LAST  = LW'(LP_CYC);
  localparam logic          REL_RAW  = ACTIVE_LOW;

  if (DB_CYC < 2 || LP_CYC <= DB_CYC) begin : g_param_check
    $error("button_debouncer: need DB_CYC >= 2 and LP_CYC > DB_CYC");
  end

  // FSM state is kept as a named enum so checkers can bind to it directly.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PRESS_WAIT = 3'd1,
    HELD       = 3'd2,
    LONG       = 3'd3,
    REL_WAIT   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [LW-1:0] lp_cnt, lp_cnt_n;
  logic          from_long, from_long_n;
  logic          sync_q1, sync_q2;
  logic          btn_s;
  logic          level_d, press_d, release_d, long_d;
  logic [7:0]    count_d;

  assign btn_s = ACTIVE_LOW ? ~sync_q2 : sync_q2;

  // State register, datapath counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1       <= REL_RAW;
      sync_q2       <= REL_RAW;
      state         <= IDLE;
      cnt           <= '0;
      lp_cnt        <= '0;
      from_long     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      sync_q1       <= btn_raw;
      sync_q2       <= sync_q1;
      state         <= state_n;
      cnt           <= cnt_n;
      lp_cnt        <= lp_cnt_n;
      from_long     <= from_long_n;
      btn_level     <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      press_count   <= count_d;
    end
  end

  // Next-state logic. The long-press hold is measured from the debounced
  // press, so lp_cnt runs up to LP_CYC while the key stays down.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    lp_cnt_n    = lp_cnt;
    from_long_n = from_long;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt + CNT_ONE == DB_LAST) begin
          state_n  = HELD;
          cnt_n    = '0;
          lp_cnt_n = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n     = REL_WAIT;
          cnt_n       = CNT_ONE;
          from_long_n = 1'b0;
        end else if (lp_cnt + LP_ONE == LP_LAST) begin
          state_n  = LONG;
          lp_cnt_n = LP_LAST;
        end else begin
          lp_cnt_n = lp_cnt + LP_ONE;
        end
      end
      LONG: begin
        if (!btn_s) begin
          state_n     = REL_WAIT;
          cnt_n       = CNT_ONE;
          from_long_n = 1'b1;
        end
      end
      REL_WAIT: begin
        // A bounce back to pressed resumes the hold where it left off.
        if (btn_s) begin
          state_n = from_long ? LONG : HELD;
          cnt_n   = '0;
        end else if (cnt + CNT_ONE == DB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CNT_ONE;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Output decode from the transition being taken; registered above.
  always_comb begin
    press_d   = (state == PRESS_WAIT) && (state_n == HELD);
    release_d = (state == REL_WAIT) && (state_n == IDLE);
    long_d    = (state == HELD) && (state_n == LONG);
    level_d   = (state_n == HELD) || (state_n == LONG) || (state_n == REL_WAIT);
    count_d   = press_d ? press_count + 8'd1 : press_count;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DB_CYC=4, LP_CYC=10; pulse events
// are predicted into a queue when the key is driven and matched when they appear.
module tb_button_debouncer;

  localparam int W = 43;
  localparam logic [2:0] EV_PRESS = 3'b001;
  localparam logic [2:0] EV_REL   = 3'b010;
  localparam logic [2:0] EV_LONG  = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_raw;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic       long_pulse;
  logic [7:0] press_count;

  int         cyc = 0;
  int         vectors = 0;
  int         miscompares = 0;
  int         press_seen = 0;
  logic [7:0] exp_count;
  logic [W-1:0] exp_q[$];

  button_debouncer #(
    .CLK_FREQ_HZ  (1000),
    .DEBOUNCE_MS  (4),
    .LONG_PRESS_MS(10),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_raw      (btn_raw),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .long_pulse   (long_pulse),
    .press_count  (press_count)
  );

  // Clock and edge counter: cyc == k when sampled #1 after the k-th edge.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_ev(input int at, input logic [2:0] kind, input logic [7:0] cnt);
    exp_q.push_back({32'(at), kind, cnt});
  endtask

  // Scoreboard: every strobe must match the next predicted {cycle, kind, count}.
  initial begin
    logic [W-1:0] obs;
    forever begin
      @(posedge clk);
      #1;
      if (press_pulse || release_pulse || long_pulse) begin
        obs = {32'(cyc), long_pulse, release_pulse, press_pulse, press_count};
        if (press_pulse) press_seen++;
        if (exp_q.size() == 0) check("unexpected_event", obs, W'(0));
        else check("event", obs, exp_q.pop_front());
      end
    end
  end

  initial begin
    int t0;
    int h;
    int g;
    int p0;

    rst       = 1'b1;
    btn_raw   = 1'b1;
    exp_count = 8'd0;
    repeat (3) tick();
    check("rst_level",   W'(btn_level),     W'(0));
    check("rst_press",   W'(press_pulse),   W'(0));
    check("rst_release", W'(release_pulse), W'(0));
    check("rst_long",    W'(long_pulse),    W'(0));
    check("rst_count",   W'(press_count),   W'(0));
    rst = 1'b0;
    repeat (2) tick();

    // Clean press and release.
    t0 = cyc;
    btn_raw = 1'b0;
    exp_count++;
    push_ev(t0 + 6, EV_PRESS, exp_count);
    wait_to(t0 + 5);
    check("press_not_early", W'(btn_level), W'(0));
    wait_to(t0 + 6);
    check("press_level", W'(btn_level), W'(1));
    check("press_count1", W'(press_count), W'(exp_count));
    wait_to(t0 + 8);
    btn_raw = 1'b1;
    push_ev(t0 + 14, EV_REL, exp_count);
    wait_to(t0 + 13);
    check("rel_not_early", W'(btn_level), W'(1));
    wait_to(t0 + 14);
    check("rel_level", W'(btn_level), W'(0));
    wait_to(t0 + 20);

    // Bounce: two 3-sample glitches never reach the debounce count.
    t0 = cyc;
    btn_raw = 1'b0;
    wait_to(t0 + 3);
    btn_raw = 1'b1;
    wait_to(t0 + 4);
    btn_raw = 1'b0;
    wait_to(t0 + 7);
    btn_raw = 1'b1;
    wait_to(t0 + 9);
    check("bounce_level_a", W'(btn_level), W'(0));
    wait_to(t0 + 16);
    check("bounce_level_b", W'(btn_level), W'(0));
    check("bounce_count", W'(press_count), W'(exp_count));

    // Long press: one long strobe 10 edges after the press.
    t0 = cyc;
    btn_raw = 1'b0;
    exp_count++;
    push_ev(t0 + 6, EV_PRESS, exp_count);
    push_ev(t0 + 16, EV_LONG, exp_count);
    wait_to(t0 + 20);
    btn_raw = 1'b1;
    push_ev(t0 + 26, EV_REL, exp_count);
    wait_to(t0 + 26);
    check("long_rel_level", W'(btn_level), W'(0));
    check("long_count", W'(press_count), W'(8'd2));
    wait_to(t0 + 32);

    // Release bounce while held: 2 high samples delay the long strobe by 3.
    t0 = cyc;
    btn_raw = 1'b0;
    exp_count++;
    push_ev(t0 + 6, EV_PRESS, exp_count);
    wait_to(t0 + 8);
    btn_raw = 1'b1;
    push_ev(t0 + 19, EV_LONG, exp_count);
    wait_to(t0 + 10);
    btn_raw = 1'b0;
    wait_to(t0 + 14);
    check("relbounce_level", W'(btn_level), W'(1));
    wait_to(t0 + 22);
    btn_raw = 1'b1;
    push_ev(t0 + 28, EV_REL, exp_count);
    wait_to(t0 + 34);

    // Reset in PRESS_WAIT, then in HELD, with the key held throughout.
    t0 = cyc;
    btn_raw = 1'b0;
    wait_to(t0 + 4);
    rst = 1'b1;
    #1;
    check("rst_pw_count", W'(press_count), W'(0));
    check("rst_pw_level", W'(btn_level), W'(0));
    exp_count = 8'd0;
    wait_to(t0 + 6);
    rst = 1'b0;
    exp_count++;
    push_ev(t0 + 12, EV_PRESS, exp_count);
    wait_to(t0 + 14);
    check("redetect_level", W'(btn_level), W'(1));
    rst = 1'b1;
    #1;
    check("rst_held_level", W'(btn_level), W'(0));
    check("rst_held_count", W'(press_count), W'(0));
    exp_count = 8'd0;
    wait_to(t0 + 16);
    rst = 1'b0;
    exp_count++;
    push_ev(t0 + 22, EV_PRESS, exp_count);
    wait_to(t0 + 24);
    btn_raw = 1'b1;
    push_ev(t0 + 30, EV_REL, exp_count);
    wait_to(t0 + 36);

    // Counter wrap: 256 presses with randomised hold and gap lengths.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = 8'd0;
    repeat (2) tick();
    check("wrap_start", W'(press_count), W'(0));
    p0 = press_seen;
    for (int k = 0; k < 256; k++) begin
      h  = int'($urandom_range(7, 12));
      g  = int'($urandom_range(6, 9));
      t0 = cyc;
      btn_raw = 1'b0;
      exp_count++;
      push_ev(t0 + 6, EV_PRESS, exp_count);
      wait_to(t0 + h);
      btn_raw = 1'b1;
      push_ev(t0 + h + 6, EV_REL, exp_count);
      if (k == 254) check("count_255", W'(press_count), W'(8'd255));
      wait_to(t0 + h + g);
    end
    t0 = cyc;
    wait_to(t0 + 10);
    check("wrap_count", W'(press_count), W'(0));
    check("wrap_strobes", W'(press_seen - p0), W'(256));
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
